// File: rtl/data_mem_stage_if.sv
// data_mem_stage_if: memory-stage data bus between the pipeline and data_mem_stage.
//   MemReadM, MemWriteM   load / store request for the instruction in M
//   ALUOut_M              byte address of the access
//   WriteData_M           store data
//   RD_M                  load data (valid in the completion cycle)
//   MemStall              access in flight; freezes PC and pipeline registers
//   MemErr                out-of-range access, flagged in the completion cycle
interface data_mem_stage_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOut_M;
    logic [31:0] WriteData_M;
    logic [31:0] RD_M;
    logic        MemStall;
    logic        MemErr;

    // Pipeline side: issues requests, consumes data and stall.
    modport master (
        output MemReadM,
        output MemWriteM,
        output ALUOut_M,
        output WriteData_M,
        input  RD_M,
        input  MemStall,
        input  MemErr
    );

    // Memory-stage side.
    modport slave (
        input  MemReadM,
        input  MemWriteM,
        input  ALUOut_M,
        input  WriteData_M,
        output RD_M,
        output MemStall,
        output MemErr
    );
endinterface

// File: rtl/data_mem_stage.sv
// data_mem_stage: memory-stage data access with a word-addressed RAM and a
// configurable access latency.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (RAM contents are not reset)
//   bus        data_mem_stage_if.slave: request inputs, RD_M / MemStall / MemErr
// Parameters:
//   ADDR_WIDTH   RAM depth is 2^ADDR_WIDTH 32-bit words
//   MEM_LATENCY  stall cycles per access (0..15); 0 is a single-cycle RAM
module data_mem_stage #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_stage_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    // Address decode: word index plus out-of-range detection on upper bits.
    logic [29:0]           word_addr_c;
    logic [ADDR_WIDTH-1:0] idx_c;
    logic                  oor_c;
    logic                  req_c;
    logic                  is_wr_c;
    logic                  is_rd_c;

    assign word_addr_c = 30'(bus.ALUOut_M >> 2);
    assign idx_c       = word_addr_c[ADDR_WIDTH-1:0];
    assign oor_c       = |word_addr_c[29:ADDR_WIDTH];
    assign req_c       = bus.MemReadM | bus.MemWriteM;
    assign is_wr_c     = bus.MemWriteM;
    // A simultaneous read+write is treated purely as a write.
    assign is_rd_c     = bus.MemReadM & ~bus.MemWriteM;

    generate
        if (MEM_LATENCY == 0) begin : g_single
            // Single-cycle RAM: write at the edge, asynchronous read.
            always_ff @(posedge clk) begin
                if (rst_n && is_wr_c && !oor_c) begin
                    mem[idx_c] <= bus.WriteData_M;
                end
            end

            assign bus.RD_M     = !rst_n                    ? '0 :
                                  (!req_c || (is_rd_c && !oor_c)) ? mem[idx_c] : '0;
            assign bus.MemStall = 1'b0;
            assign bus.MemErr   = rst_n & req_c & oor_c;
        end else begin : g_multi
            typedef enum logic [1:0] {
                IDLE = 2'd0,
                WAIT = 2'd1,
                DONE = 2'd2
            } state_t;

            localparam logic [3:0] CNT_INIT  = 4'(MEM_LATENCY - 1);
            localparam bit         ONE_CYCLE = (MEM_LATENCY == 1);

            state_t                state_q;
            state_t                state_d;
            logic [3:0]            cnt_q;
            logic [3:0]            cnt_d;
            logic                  latch_c;
            logic                  fire_c;
            logic                  fire_live_c;

            logic                  wr_q;
            logic                  rd_q;
            logic                  oor_q;
            logic [ADDR_WIDTH-1:0] idx_q;
            logic [31:0]           wdata_q;
            logic [31:0]           rdata_q;

            // Operands of the access performed this edge: live inputs for a
            // one-cycle access straight out of IDLE, latched copies otherwise.
            logic                  acc_wr_c;
            logic                  acc_rd_c;
            logic                  acc_oor_c;
            logic [ADDR_WIDTH-1:0] acc_idx_c;
            logic [31:0]           acc_wdata_c;

            // Next-state logic.
            always_comb begin
                state_d     = state_q;
                cnt_d       = cnt_q;
                latch_c     = 1'b0;
                fire_c      = 1'b0;
                fire_live_c = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (req_c) begin
                            latch_c = 1'b1;
                            cnt_d   = CNT_INIT;
                            if (ONE_CYCLE) begin
                                fire_c      = 1'b1;
                                fire_live_c = 1'b1;
                                state_d     = DONE;
                            end else begin
                                state_d = WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        // cnt stops at 1; it never wraps.
                        if (cnt_q == 4'd1) begin
                            fire_c  = 1'b1;
                            state_d = DONE;
                        end else begin
                            cnt_d = 4'(cnt_q - 4'd1);
                        end
                    end
                    DONE: begin
                        // The completing instruction is still on the inputs;
                        // its request is deliberately ignored here.
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end

            assign acc_wr_c    = fire_live_c ? is_wr_c        : wr_q;
            assign acc_rd_c    = fire_live_c ? is_rd_c        : rd_q;
            assign acc_oor_c   = fire_live_c ? oor_c          : oor_q;
            assign acc_idx_c   = fire_live_c ? idx_c          : idx_q;
            assign acc_wdata_c = fire_live_c ? bus.WriteData_M : wdata_q;

            // State, counter, latched request and read-data register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    oor_q   <= 1'b0;
                    idx_q   <= '0;
                    wdata_q <= '0;
                    rdata_q <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    if (latch_c) begin
                        wr_q    <= is_wr_c;
                        rd_q    <= is_rd_c;
                        oor_q   <= oor_c;
                        idx_q   <= idx_c;
                        wdata_q <= bus.WriteData_M;
                    end
                    if (fire_c) begin
                        rdata_q <= (acc_rd_c && !acc_oor_c) ? mem[acc_idx_c] : '0;
                    end
                end
            end

            // RAM write port; a reset edge discards a pending store.
            always_ff @(posedge clk) begin
                if (rst_n && fire_c && acc_wr_c && !acc_oor_c) begin
                    mem[acc_idx_c] <= acc_wdata_c;
                end
            end

            assign bus.MemStall = rst_n & (((state_q == IDLE) & req_c) | (state_q == WAIT));
            assign bus.RD_M     = rdata_q;
            assign bus.MemErr   = (state_q == DONE) & oor_q;
        end
    endgenerate
endmodule

// File: tb/tb_data_mem_stage.sv
// tb_data_mem_stage: drives five data_mem_stage instances (latencies 0,2,3,4,1)
// and compares each access against a transaction-level memory model.
module tb_data_mem_stage;
    localparam int          NDUT = 5;
    localparam int unsigned AW   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a [NDUT];
    logic        rd_a    [NDUT];
    logic        wr_a    [NDUT];
    logic [31:0] addr_a  [NDUT];
    logic [31:0] wd_a    [NDUT];
    logic [31:0] rdm_a   [NDUT];
    logic [31:0] mw_a    [NDUT];
    logic        stall_a [NDUT];
    logic        err_a   [NDUT];

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : g_dut
            localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 2 :
                                          (g == 2) ? 3 : (g == 3) ? 4 : 1;
            data_mem_stage_if bus ();
            logic [31:0] mw_q;

            assign bus.MemReadM    = rd_a[g];
            assign bus.MemWriteM   = wr_a[g];
            assign bus.ALUOut_M    = addr_a[g];
            assign bus.WriteData_M = wd_a[g];
            assign rdm_a[g]        = bus.RD_M;
            assign stall_a[g]      = bus.MemStall;
            assign err_a[g]        = bus.MemErr;
            assign mw_a[g]         = mw_q;

            data_mem_stage #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) u_dut (
                .clk   (clk),
                .rst_n (rst_n_a[g]),
                .bus   (bus)
            );

            // M-to-W pipeline register: frozen while the stage stalls.
            always_ff @(posedge clk) begin
                if (!stall_a[g]) mw_q <= rdm_a[g];
            end
        end
    endgenerate

    function automatic int lat_of(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            default: return 1;
        endcase
    endfunction

    // Reference memory per instance; only words written by the bench are known.
    logic [31:0] mdl   [NDUT][256];
    bit          known [NDUT][256];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access; called just after a rising edge. Returns just after the
    // edge that ends the completion cycle, with the request dropped.
    task automatic access(input int i, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wd);
        int          stalls;
        bit          oor;
        bit          chk_data;
        logic [7:0]  idx;
        logic [31:0] exp_rd;
        oor    = (addr[31:AW+2] != 0);
        idx    = addr[AW+1:2];
        stalls = 0;
        if (wr || oor) begin
            exp_rd   = 32'h0;
            chk_data = 1'b1;
        end else begin
            exp_rd   = mdl[i][idx];
            chk_data = known[i][idx];
        end
        rd_a[i] = rd; wr_a[i] = wr; addr_a[i] = addr; wd_a[i] = wd;
        @(negedge clk);
        while (stall_a[i] && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        chk($sformatf("stall_len[%0d]", i), 32'(stalls), 32'(lat_of(i)));
        chk($sformatf("mem_err[%0d]", i), 32'(err_a[i]), 32'((rd | wr) & oor));
        if (chk_data) chk($sformatf("rd_m[%0d] @%h", i, addr), rdm_a[i], exp_rd);
        @(posedge clk); #1;
        rd_a[i] = 1'b0; wr_a[i] = 1'b0;
        if (rd && !wr && chk_data) chk($sformatf("mw_reg[%0d]", i), mw_a[i], exp_rd);
        if (wr && !oor) begin
            mdl[i][idx]   = wd;
            known[i][idx] = 1'b1;
        end
    endtask

    task automatic idle_cycle(input int i);
        rd_a[i] = 1'b0; wr_a[i] = 1'b0; addr_a[i] = $urandom;
        @(negedge clk);
        chk($sformatf("idle_stall[%0d]", i), 32'(stall_a[i]), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rst_n_a[i] = 1'b0; rd_a[i] = 1'b0; wr_a[i] = 1'b0;
            addr_a[i] = '0; wd_a[i] = '0;
        end
        // Reset with a pending load on the L=2 instance (out-of-range address).
        rd_a[1] = 1'b1; addr_a[1] = 32'h0000_0400;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_stall", 32'(stall_a[1]), 32'h0);
            chk("rst_rd_m", rdm_a[1], 32'h0);
            chk("rst_err", 32'(err_a[1]), 32'h0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NDUT; i++) rst_n_a[i] = 1'b1;
        access(1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);

        // L=0: store then load.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("l0_load_value", mdl[0][4], 32'hDEAD_BEEF);

        // L=3: load of a previously stored word.
        access(2, 1'b0, 1'b1, 32'h24, 32'h1234_5678);
        access(2, 1'b1, 1'b0, 32'h24, 32'h0);

        // L=2: read+write is a write; out-of-range write is dropped.
        access(1, 1'b1, 1'b1, 32'h08, 32'hA5A5_A5A5);
        access(1, 1'b1, 1'b0, 32'h08, 32'h0);
        access(1, 1'b1, 1'b1, 32'h408, 32'h5A5A_5A5A);
        access(1, 1'b1, 1'b0, 32'h08, 32'h0);

        // L=4: reset in the 2nd stall cycle of a store discards it.
        access(3, 1'b0, 1'b1, 32'h0C, 32'h0000_0055);
        wr_a[3] = 1'b1; addr_a[3] = 32'h0C; wd_a[3] = 32'h1;
        @(negedge clk);
        chk("midrst_stall1", 32'(stall_a[3]), 32'h1);
        @(posedge clk); #1;
        rst_n_a[3] = 1'b0;
        @(negedge clk);
        chk("midrst_stall_in_rst", 32'(stall_a[3]), 32'h0);
        @(posedge clk); #1;
        rst_n_a[3] = 1'b1; wr_a[3] = 1'b0;
        @(negedge clk);
        chk("midrst_idle_stall", 32'(stall_a[3]), 32'h0);
        chk("midrst_err", 32'(err_a[3]), 32'h0);
        chk("midrst_rd_m", rdm_a[3], 32'h0);
        @(posedge clk); #1;
        access(3, 1'b1, 1'b0, 32'h0C, 32'h0);

        // Randomized traffic on every instance over a small hot set of words.
        for (int i = 0; i < NDUT; i++) begin
            for (int w = 0; w < 16; w++) access(i, 1'b0, 1'b1, 32'(w * 4), $urandom);
            for (int n = 0; n < 40; n++) begin
                int          op;
                logic [31:0] a;
                op = $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) begin
                    a = $urandom;
                    if (a[31:AW+2] == 0) a[31] = 1'b1;
                end else begin
                    a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
                end
                case (op)
                    0:       access(i, 1'b1, 1'b0, a, $urandom);
                    1:       access(i, 1'b0, 1'b1, a, $urandom);
                    2:       access(i, 1'b1, 1'b1, a, $urandom);
                    default: idle_cycle(i);
                endcase
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

Memory-stage data-access block of the five-stage pipeline. It sits between the execute-to-memory pipeline register and the memory-to-writeback pipeline register. It owns the word-addressed data RAM and models a configurable-latency memory. While an access is in flight it raises a stall, and it presents read data on RD_M in the cycle the writeback register captures it.

## Interface
- ADDR_WIDTH, 8: RAM depth is 2^ADDR_WIDTH 32-bit words.
- MEM_LATENCY, 2: number of stall cycles per access. Legal range is 0..15; 0 means single-cycle.
- clk  in  1  rising-edge clock; only clock.
- rst_n  in  1  reset: synchronous, active-low.
- MemReadM  in  1  load request for the instruction in M.
- MemWriteM  in  1  store request for the instruction in M.
- ALUOut_M  in  32  byte address. Word index = ALUOut_M[ADDR_WIDTH+1:2]; bits [1:0] are ignored.
- WriteData_M  in  32  store data.
- RD_M  out  32  load data, valid in the completion cycle.
- MemStall  out  1  high while an access is in flight; freezes PC, all upstream registers and the M-to-W register.
- MemErr  out  1  high in the completion cycle if ALUOut_M[31:ADDR_WIDTH+2] != 0.

## Operation
- Request (req): MemReadM | MemWriteM.
  - If both are high, the access is a write. No read occurs and RD_M = 0.
- Out-of-range request:
  - Write is dropped.
  - Read returns 0.
  - MemErr = 1 in the completion cycle.
  - Timing is identical to an in-range access.
- The RAM is not reset; its contents survive rst_n.
- MEM_LATENCY = 0 (no FSM activity):
  - Read is asynchronous: RD_M = mem[idx] combinationally.
  - Write commits at the clock edge.
  - MemStall is constantly 0.
- MEM_LATENCY = L > 0 uses a three-state FSM.
  - IDLE:
    - MemStall = req.
    - On req, latch the access type, word index, WriteData and the out-of-range flag, and load cnt <= L-1.
    - If L == 1, perform the access at this edge and go to DONE. Otherwise go to WAIT.
    - Without req, stay in IDLE.
  - WAIT:
    - MemStall = 1.
    - If cnt == 1, perform the latched access at this edge: a write updates mem, a read loads rdata_q. Then go to DONE.
    - Otherwise decrement cnt.
  - DONE:
    - MemStall = 0. RD_M = rdata_q (0 after a write or an out-of-range read). MemErr = latched flag.
    - Go to IDLE unconditionally. The inputs still show the completing instruction; its req is ignored.
- RD_M outside the completion cycle: holds rdata_q (L>0) or shows the async read (L=0).
  - Downstream uses it only when MemtoReg is set.
- Inputs are stable during stall because upstream is frozen. The block still uses the latched copies.

## Timing
- Reset (rst_n low at an edge) sets:
  - state = IDLE, cnt = 0, rdata_q = 0, latched request cleared.
  - RD_M = 0, MemErr = 0.
  - MemStall = 0 while rst_n is low, regardless of req.
- Reset mid-WAIT: a pending write is discarded and the RAM is unchanged. The next access after reset sees the old data.
- Latency with L > 0:
  - MemStall is high for exactly L consecutive cycles, starting combinationally in the request cycle.
  - The completion cycle immediately follows, with MemStall low.
  - The M-to-W register captures RD_M at the end of the completion cycle.
- Back-to-back accesses: the next instruction enters M in the cycle after DONE (IDLE), so a load sees a store one instruction earlier.
- A non-memory instruction in IDLE has MemStall = 0 and zero overhead.
- cnt is 4 bits wide and never wraps: it is loaded only in IDLE and stops at 1.

## Test plan
- Reset, L = 2: hold rst_n low 3 cycles with MemReadM = 1. Expect MemStall = 0, RD_M = 0, MemErr = 0. Release: expect MemStall high for the next 2 cycles.
- L = 0, store then load: store 0xDEADBEEF to address 0x10, then load 0x10. Expect MemStall never asserted and RD_M = 0xDEADBEEF in the load cycle.
- L = 3, load of address 0x24 holding 0x12345678: expect MemStall = 1,1,1,0. Expect RD_M = 0x12345678 in the 4th cycle, and the M-to-W register's captured value equals it.
- L = 2, MemReadM and MemWriteM both high, data 0xA5A5A5A5 to 0x08:
  - Expect RD_M = 0 at completion.
  - A following load of 0x08 returns 0xA5A5A5A5.
  - Address 0x08 + 0x400 (ADDR_WIDTH = 8) gives MemErr = 1 at completion and the RAM is unchanged.
- L = 4, reset mid-WAIT: assert rst_n low during a store of 0x1 to 0x0C, in the 2nd stall cycle. Expect MemStall = 0 during reset and state IDLE after release. A later load of 0x0C returns the pre-store value.
